// File: rtl/hwpe_sel_ctrl.sv
// hwpe_sel_ctrl: register-mapped HWPE select/enable controller with a
// drain-then-gate switchover. Optional macro: HWPE_SEL_CTRL_BUSY_TIMEOUT_EN.
// Ports: clk, rst_n; periph bus req_i/add_i/wen_i/be_i/wdata_i/id_i ->
// gnt_o, r_rdata_o/r_valid_o/r_id_o; busy_i in; hwpe_en_o/hwpe_sel_o out.
module hwpe_sel_ctrl #(
  parameter int ID_WIDTH      = 8,
  parameter int MAX_NUM_HWPES = 4,
  parameter int GUARD_CYCLES  = 4,
  localparam int SW = (MAX_NUM_HWPES > 1) ?
                      $clog2(MAX_NUM_HWPES) : 1,
  localparam int CW = (GUARD_CYCLES > 1) ?
                      $clog2(GUARD_CYCLES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [31:0]         add_i,
  input  logic                wen_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         wdata_i,
  input  logic [ID_WIDTH-1:0] id_i,
  output logic                gnt_o,
  output logic [31:0]         r_rdata_o,
  output logic                r_valid_o,
  output logic [ID_WIDTH-1:0] r_id_o,
  input  logic                busy_i,
  output logic                hwpe_en_o,
  output logic [SW-1:0]       hwpe_sel_o
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    GATE
  } state_t;

  localparam logic [CW-1:0] LOAD = CW'(GUARD_CYCLES - 1);

  state_t        state;
  logic          ctrl_en;
  logic [SW-1:0] ctrl_sel;
  logic          pend_en;
  logic [SW-1:0] pend_sel;
  logic [CW-1:0] cnt;
  logic [15:0]   sw_cnt;

  logic          is_ctrl;
  logic          is_stat;
  logic          is_cnt;
  logic          is_none;
  logic          wr_ctrl;
  logic          ctrl_wr;
  logic          new_en;
  logic [SW-1:0] new_sel;
  logic [31:0]   rdata;
  logic          wd_exp;
  logic          to_flag;
  logic          unused_ok;

  assign unused_ok = ^{add_i, be_i, wdata_i};

  assign is_ctrl = (add_i[3:2] == 2'd0);
  assign is_stat = (add_i[3:2] == 2'd1);
  assign is_cnt  = (add_i[3:2] == 2'd2);
  assign is_none = (add_i[3:2] == 2'd3);

  assign wr_ctrl = req_i && !wen_i && is_ctrl;
  assign gnt_o   = req_i && !(wr_ctrl && state != RUN);
  assign ctrl_wr = gnt_o && wr_ctrl;

  // Byte-lane merge against the stored CTRL value.
  assign new_en  = be_i[0] ? wdata_i[0] : ctrl_en;
  assign new_sel = be_i[1] ? wdata_i[8+:SW] : ctrl_sel;

`ifdef HWPE_SEL_CTRL_BUSY_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_exp = (state == DRAIN) && busy_i &&
                  (wd_cnt == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == DRAIN && !wd_exp) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (wd_exp) begin
        to_flag <= 1'b1;
      end else if (ctrl_wr) begin
        to_flag <= 1'b0;
      end
    end
  end
`else
  assign wd_exp  = 1'b0;
  assign to_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      ctrl_en    <= 1'b0;
      ctrl_sel   <= '0;
      pend_en    <= 1'b0;
      pend_sel   <= '0;
      cnt        <= '0;
      sw_cnt     <= '0;
      hwpe_en_o  <= 1'b0;
      hwpe_sel_o <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en  <= new_en;
        ctrl_sel <= new_sel;
      end
      unique case (state)
        RUN: begin
          if (ctrl_wr) begin
            if (new_sel == hwpe_sel_o) begin
              hwpe_en_o <= new_en;
            end else begin
              pend_sel <= new_sel;
              pend_en  <= new_en;
              if (busy_i) begin
                state <= DRAIN;
              end else begin
                state     <= GATE;
                cnt       <= LOAD;
                hwpe_en_o <= 1'b0;
              end
            end
          end
        end
        DRAIN: begin
          if (!busy_i || wd_exp) begin
            state     <= GATE;
            cnt       <= LOAD;
            hwpe_en_o <= 1'b0;
          end
        end
        GATE: begin
          if (cnt == '0) begin
            hwpe_sel_o <= pend_sel;
            hwpe_en_o  <= pend_en;
            sw_cnt     <= sw_cnt + 16'd1;
            state      <= RUN;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ctrl: begin
        rdata[0]     = ctrl_en;
        rdata[8+:SW] = ctrl_sel;
      end
      is_stat: begin
        rdata[0]      = busy_i;
        rdata[1]      = (state != RUN);
        rdata[2]      = to_flag;
        rdata[8+:SW]  = hwpe_sel_o;
        rdata[16+:SW] = pend_sel;
      end
      is_cnt:  rdata[15:0] = sw_cnt;
      is_none: rdata = '0;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_o <= 1'b0;
      r_rdata_o <= '0;
      r_id_o    <= '0;
    end else begin
      r_valid_o <= gnt_o;
      if (gnt_o) begin
        r_id_o <= id_i;
      end
      r_rdata_o <= (gnt_o && wen_i) ? rdata : '0;
    end
  end

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
// tb_hwpe_sel_ctrl: directed + random bench for hwpe_sel_ctrl
// against a transaction-level model of the switch rules.
module tb_hwpe_sel_ctrl;

  localparam int NH = 4;
  localparam int G  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  id;
  logic        gnt;
  logic [31:0] r_rdata;
  logic        r_valid;
  logic [7:0]  r_id;
  logic        busy;
  logic        hwpe_en;
  logic [1:0]  hwpe_sel;

  int errors = 0;
  int checks = 0;

  int m_en, m_sel, m_hen, m_hsel, m_pend, m_cnt;

  hwpe_sel_ctrl #(
    .ID_WIDTH(8),
    .MAX_NUM_HWPES(NH),
    .GUARD_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req),
    .add_i(add),
    .wen_i(wen),
    .be_i(be),
    .wdata_i(wdata),
    .id_i(id),
    .gnt_o(gnt),
    .r_rdata_o(r_rdata),
    .r_valid_o(r_valid),
    .r_id_o(r_id),
    .busy_i(busy),
    .hwpe_en_o(hwpe_en),
    .hwpe_sel_o(hwpe_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_sel = 0; m_hen = 0;
    m_hsel = 0; m_pend = 0; m_cnt = 0;
  endtask

  function automatic logic [31:0] exp_status(input int pending);
    return 32'(pending * 2 + m_hsel * 256 + m_pend * 65536);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the response.
  task automatic bus(input logic w, input logic [1:0] a,
                     input logic [3:0] b, input logic [31:0] d,
                     output logic [31:0] rd, output int stalls);
    logic [7:0] tid;
    tid = 8'($urandom);
    req = 1'b1; wen = w; add = {28'h0, a, 2'b00};
    be = b; wdata = d; id = tid; stalls = 0;
    @(negedge clk);
    while (!gnt && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    chk("gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("r_valid", 32'(r_valid), 32'd1);
    chk("r_id", 32'(r_id), 32'(tid));
    if (!w) chk("wr_rdata", r_rdata, 32'd0);
    rd = r_rdata;
  endtask

  task automatic rd_chk(input logic [1:0] a,
                        input logic [31:0] exp,
                        input string tag);
    logic [31:0] rd;
    int st;
    bus(1'b1, a, 4'h0, 32'h0, rd, st);
    chk(tag, rd, exp);
    chk({tag, "_stall"}, 32'(st), 32'd0);
  endtask

  // Write CTRL; n = cycles busy is held after the write (0 = idle).
  task automatic do_ctrl(input logic [31:0] d,
                         input logic [3:0] b, input int n);
    logic [31:0] rd;
    int st, ns_en, ns_sel;
    bit sw;
    ns_en  = b[0] ? int'(d[0]) : m_en;
    ns_sel = b[1] ? int'((d >> 8) % NH) : m_sel;
    sw = (ns_sel != m_hsel);
    busy = (sw && n > 0);
    bus(1'b0, 2'd0, b, d, rd, st);
    chk("ctrl_nostall", 32'(st), 32'd0);
    m_en = ns_en;
    m_sel = ns_sel;
    if (!sw) begin
      chk("same_en", 32'(hwpe_en), 32'(ns_en));
      chk("same_sel", 32'(hwpe_sel), 32'(m_hsel));
      m_hen = ns_en;
    end else begin
      m_pend = ns_sel;
      if (n > 0) begin
        chk("drain_en0", 32'(hwpe_en), 32'(m_hen));
        for (int i = 0; i < n; i++) begin
          @(posedge clk); #1;
          chk("drain_sel", 32'(hwpe_sel), 32'(m_hsel));
          chk("drain_en", 32'(hwpe_en), 32'(m_hen));
        end
        busy = 1'b0;
        for (int i = 0; i < G; i++) begin
          @(posedge clk); #1;
          chk("gate_en", 32'(hwpe_en), 32'd0);
          chk("gate_sel", 32'(hwpe_sel), 32'(m_hsel));
        end
      end else begin
        chk("gate_en", 32'(hwpe_en), 32'd0);
        for (int i = 0; i < G - 1; i++) begin
          @(posedge clk); #1;
          chk("gate_en", 32'(hwpe_en), 32'd0);
          chk("gate_sel", 32'(hwpe_sel), 32'(m_hsel));
        end
      end
      @(posedge clk); #1;
      chk("new_sel", 32'(hwpe_sel), 32'(ns_sel));
      chk("new_en", 32'(hwpe_en), 32'(ns_en));
      m_hsel = ns_sel;
      m_hen = ns_en;
      m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  initial begin
    logic [31:0] rd;
    int st;
    logic [7:0] ida, idb;
    rst_n = 1'b0; req = 1'b0; add = '0; wen = 1'b1;
    be = '0; wdata = '0; id = '0; busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(hwpe_en), 32'd0);
    chk("rst_sel", 32'(hwpe_sel), 32'd0);
    chk("rst_rvalid", 32'(r_valid), 32'd0);
    chk("rst_rdata", r_rdata, 32'd0);
    chk("rst_rid", 32'(r_id), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk(2'd0, 32'd0, "rst_ctrl");
    rd_chk(2'd1, 32'd0, "rst_status");
    rd_chk(2'd2, 32'd0, "rst_swcnt");
    rd_chk(2'd3, 32'd0, "rd_hole");

    do_ctrl(32'h0000_0001, 4'hF, 0);
    rd_chk(2'd1, exp_status(0), "status_run");
    do_ctrl(32'h0000_0101, 4'hF, 10);
    rd_chk(2'd2, 32'd1, "swcnt_1");
    rd_chk(2'd0, 32'h101, "ctrl_101");

    // Switch to 2, then STATUS read and a stalled CTRL write in GATE.
    bus(1'b0, 2'd0, 4'hF, 32'h0000_0201, rd, st);
    chk("gate_entry_en", 32'(hwpe_en), 32'd0);
    m_sel = 2; m_en = 1; m_pend = 2;
    bus(1'b1, 2'd1, 4'h0, 32'h0, rd, st);
    chk("gate_stat_stall", 32'(st), 32'd0);
    chk("gate_status", rd, exp_status(1));
    bus(1'b0, 2'd0, 4'hF, 32'h0000_0200, rd, st);
    chk("ctrl_stall", 32'(st), 32'(G - 1));
    m_hsel = 2; m_cnt++; m_en = 0; m_hen = 0;
    chk("stall_sel", 32'(hwpe_sel), 32'd2);
    chk("stall_en", 32'(hwpe_en), 32'd0);
    rd_chk(2'd2, 32'(m_cnt), "swcnt_2");

    // Writes to the hole are ignored.
    bus(1'b0, 2'd3, 4'hF, 32'hFFFF_FFFF, rd, st);
    rd_chk(2'd0, 32'(m_sel * 256 + m_en), "ctrl_after_hole");

    for (int k = 0; k < 16; k++) begin
      do_ctrl($urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4));
      rd_chk(2'd0, 32'(m_sel * 256 + m_en), "rnd_ctrl");
      rd_chk(2'd1, exp_status(0), "rnd_status");
      rd_chk(2'd2, 32'(m_cnt), "rnd_swcnt");
    end

    // Back-to-back reads.
    ida = 8'h3; idb = 8'h7;
    req = 1'b1; wen = 1'b1; add = 32'h4; id = ida;
    @(negedge clk);
    chk("b2b_gnt0", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    add = 32'h8; id = idb;
    chk("b2b_v0", 32'(r_valid), 32'd1);
    chk("b2b_id0", 32'(r_id), 32'(ida));
    chk("b2b_d0", r_rdata, exp_status(0));
    @(negedge clk);
    chk("b2b_gnt1", 32'(gnt), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    chk("b2b_v1", 32'(r_valid), 32'd1);
    chk("b2b_id1", 32'(r_id), 32'(idb));
    chk("b2b_d1", r_rdata, 32'(m_cnt));
    @(posedge clk); #1;
    chk("b2b_idle", 32'(r_valid), 32'd0);

    // Reset in the middle of GATE.
    do_ctrl(32'h0000_0301, 4'hF, 0);
    bus(1'b0, 2'd0, 4'hF, 32'h0000_0001, rd, st);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(hwpe_en), 32'd0);
    chk("arst_sel", 32'(hwpe_sel), 32'd0);
    chk("arst_rvalid", 32'(r_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rd_chk(2'd2, 32'd0, "arst_swcnt");
    rd_chk(2'd1, 32'd0, "arst_status");
    rd_chk(2'd0, 32'd0, "arst_ctrl");
    chk("arst_en2", 32'(hwpe_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
